// File: rtl/cpu_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// cpu_mul_arbiter_if
// Bundles every signal between the multiplier arbiter and its environment.
// The environment is the requesters, the response consumer and the pipelined
// multiplier.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   requester index width, clog2(NREQ), minimum 1
//
// Signals:
//   req_valid / req_ready  per-requester operand handshake (ready one-hot or 0)
//   req_a / req_b          32-bit signed operands, requester i at [32i+31:32i]
//   rsp_valid / rsp_ready  product handshake towards the consumer
//   rsp_data / rsp_id      64-bit signed product and index of its owner
//   mul_ce                 clock enable of the multiplier output register
//   mul_din0 / mul_din1    operands driven into the multiplier
//   mul_dout               multiplier output register contents
//
// Modports:
//   slave   the arbiter's view
//   master  the environment's view
// -----------------------------------------------------------------------------
interface cpu_mul_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_a;
   logic [32*NREQ-1:0]   req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [63:0]          rsp_data;
   logic [IDW-1:0]       rsp_id;
   logic                 mul_ce;
   logic [31:0]          mul_din0;
   logic [31:0]          mul_din1;
   logic [63:0]          mul_dout;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_dout,
      output req_ready, rsp_valid, rsp_data, rsp_id, mul_ce, mul_din0, mul_din1
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_dout,
      input  req_ready, rsp_valid, rsp_data, rsp_id, mul_ce, mul_din0, mul_din1
   );
endinterface

// File: rtl/cpu_mul_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_mul_arbiter
// This block is a round-robin arbiter and sequencer for one shared, signed
// 32x32->64 multiplier. The multiplier has a single ce-gated output register.
//
// Each cycle the arbiter grants at most one operand pair and drives that pair
// into the multiplier. It tracks which requester owns the product sitting in
// the multiplier's output register. While the consumer back-pressures, the
// arbiter drops mul_ce so that the held product stays stable.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   bus          cpu_mul_arbiter_if.slave (request, response, multiplier)
//   stat_issued  issue counter        (only with CPU_MUL_ARB_STATS_EN)
//   stat_stall   stalled-cycle counter (only with CPU_MUL_ARB_STATS_EN)
//
// Optional feature macro: CPU_MUL_ARB_STATS_EN. It adds the two
// free-running counters stat_issued and stat_stall.
// -----------------------------------------------------------------------------
module cpu_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              reset,
`ifdef CPU_MUL_ARB_STATS_EN
   output logic [31:0]       stat_issued,
   output logic [31:0]       stat_stall,
`endif
   cpu_mul_arbiter_if.slave  bus
);

   // The output slot mirrors the contents of the multiplier output register.
   logic            s_valid_q, s_valid_d;
   logic [IDW-1:0]  s_id_q,    s_id_d;
   logic [IDW-1:0]  rr_ptr_q,  rr_ptr_d;

   logic            any_req_s;
   logic            found_s;
   logic [IDW-1:0]  gid_s;
   logic [IDW:0]    sum_s;
   logic [IDW-1:0]  idx_s;
   logic            advance_s;
   logic            issue_s;
   logic [NREQ-1:0] req_ready_s;
   logic [31:0]     din0_s;
   logic [31:0]     din1_s;

`ifdef CPU_MUL_ARB_STATS_EN
   logic [31:0]     stat_issued_q, stat_issued_d;
   logic [31:0]     stat_stall_q,  stat_stall_d;
`endif

   // Round-robin search: the first valid requester at or above rr_ptr wins.
   // The search wraps around past the top requester.
   always_comb begin
      found_s = 1'b0;
      gid_s   = '0;
      sum_s   = '0;
      idx_s   = '0;
      for (int i = 0; i < NREQ; i++) begin
         // rr_ptr and i are both below NREQ, so one subtraction is
         // enough to wrap the sum.
         sum_s = {1'b0, rr_ptr_q} + (IDW+1)'(i);
         if (sum_s >= (IDW+1)'(NREQ)) begin
            sum_s = sum_s - (IDW+1)'(NREQ);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[IDW-1:0];
         if (!found_s && bus.req_valid[idx_s]) begin
            found_s = 1'b1;
            gid_s   = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Handshake and multiplier drive. All outputs are forced quiet during reset.
   always_comb begin
      any_req_s   = |bus.req_valid;
      advance_s   = !s_valid_q || bus.rsp_ready;
      issue_s     = advance_s && any_req_s && !reset;
      req_ready_s = '0;
      din0_s      = 32'd0;
      din1_s      = 32'd0;
      if (issue_s) begin
         req_ready_s[gid_s] = 1'b1;
      end else begin
         req_ready_s = '0;
      end
      if (any_req_s && !reset) begin
         din0_s = bus.req_a[{gid_s, 5'd0} +: 32];
         din1_s = bus.req_b[{gid_s, 5'd0} +: 32];
      end else begin
         din0_s = 32'd0;
         din1_s = 32'd0;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.mul_ce    = advance_s && !reset;
   assign bus.mul_din0  = din0_s;
   assign bus.mul_din1  = din1_s;
   assign bus.rsp_valid = s_valid_q && !reset;
   assign bus.rsp_data  = bus.mul_dout;
   assign bus.rsp_id    = s_id_q;

   // Next slot/pointer state. Everything holds while the multiplier is stalled.
   always_comb begin
      s_valid_d = s_valid_q;
      s_id_d    = s_id_q;
      rr_ptr_d  = rr_ptr_q;
      if (advance_s) begin
         s_valid_d = issue_s;
         s_id_d    = gid_s;
      end else begin
         s_valid_d = s_valid_q;
         s_id_d    = s_id_q;
      end
      if (issue_s) begin
         rr_ptr_d = (gid_s == IDW'(NREQ - 1)) ? '0 : gid_s + IDW'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Slot and pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_valid_q <= 1'b0;
         s_id_q    <= '0;
         rr_ptr_q  <= '0;
      end else begin
         s_valid_q <= s_valid_d;
         s_id_q    <= s_id_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

`ifdef CPU_MUL_ARB_STATS_EN
   // Counter increments. Both counters wrap naturally at 2^32.
   always_comb begin
      stat_issued_d = stat_issued_q;
      stat_stall_d  = stat_stall_q;
      if (issue_s) begin
         stat_issued_d = stat_issued_q + 32'd1;
      end else begin
         stat_issued_d = stat_issued_q;
      end
      if (s_valid_q && !bus.rsp_ready) begin
         stat_stall_d = stat_stall_q + 32'd1;
      end else begin
         stat_stall_d = stat_stall_q;
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_issued_q <= 32'd0;
         stat_stall_q  <= 32'd0;
      end else begin
         stat_issued_q <= stat_issued_d;
         stat_stall_q  <= stat_stall_d;
      end
   end

   assign stat_issued = stat_issued_q;
   assign stat_stall  = stat_stall_q;
`endif

endmodule
